// File: rtl/act_unit_pipe.sv
// Two-stage per-lane activation (bypass / ReLU / clipped ReLU / leaky ReLU) with valid/ready.
// Optional saturating neg/clip statistics counters are built when ACT_STAT_EN is defined.
module act_unit_pipe #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CH           = 4,
  parameter int unsigned LEAK_SHIFT_W = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [CH*DATA_W-1:0]    s_data,
  input  logic [1:0]              s_mode,
  input  logic [DATA_W-1:0]       s_clip,
  input  logic [LEAK_SHIFT_W-1:0] s_leak_sh,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [CH*DATA_W-1:0]    m_data
`ifdef ACT_STAT_EN
  ,
  input  logic                    stat_clr,
  output logic [15:0]             neg_cnt,
  output logic [15:0]             clip_cnt
`endif
);

  logic                   w_en1, w_en2;
  logic                   r_v1, r_v2;
  logic [CH*DATA_W-1:0]   r_x1, r_lk1, r_y2;
  logic [CH-1:0]          r_neg1;
  logic [1:0]             r_mode1;
  logic [DATA_W-1:0]      r_clip1;

  logic [CH*DATA_W-1:0]   w_lk, w_y;
  logic [CH-1:0]          w_neg;
  logic signed [DATA_W-1:0] w_lane1;
  logic signed [DATA_W-1:0] w_x2, w_lk2, w_clip2, w_yl;

`ifdef ACT_STAT_EN
  logic [15:0] w_neg_pop, w_clip_pop;
  logic [16:0] w_neg_sum, w_clip_sum;
  logic [15:0] r_neg_cnt, r_clip_cnt;
`endif

  assign w_en2   = !r_v2 || m_ready;
  assign w_en1   = !r_v1 || w_en2;
  assign s_ready = w_en1;
  assign m_valid = r_v2;
  assign m_data  = r_y2;

  // Stage 1: sign flag and leaky value precomputed from the raw lane.
  always_comb begin
    w_lk    = '0;
    w_neg   = '0;
    w_lane1 = '0;
    for (int k = 0; k < int'(CH); k++) begin
      w_lane1                  = s_data[k*DATA_W +: DATA_W];
      w_neg[k]                 = w_lane1[DATA_W-1];
      w_lk[k*DATA_W +: DATA_W] = w_lane1 >>> s_leak_sh;
    end
  end

  // Stage 2: select the activation per lane.
  always_comb begin
    w_y     = '0;
    w_x2    = '0;
    w_lk2   = '0;
    w_yl    = '0;
    w_clip2 = r_clip1;
`ifdef ACT_STAT_EN
    w_neg_pop  = '0;
    w_clip_pop = '0;
`endif
    for (int k = 0; k < int'(CH); k++) begin
      w_x2  = r_x1[k*DATA_W +: DATA_W];
      w_lk2 = r_lk1[k*DATA_W +: DATA_W];
      case (r_mode1)
        2'd0:    w_yl = w_x2;
        2'd1:    w_yl = r_neg1[k] ? '0 : w_x2;
        2'd2: begin
          // A negative ceiling forces every lane to zero.
          if (r_neg1[k] || r_clip1[DATA_W-1]) w_yl = '0;
          else if (w_x2 > w_clip2)            w_yl = w_clip2;
          else                                w_yl = w_x2;
        end
        default: w_yl = r_neg1[k] ? w_lk2 : w_x2;
      endcase
      w_y[k*DATA_W +: DATA_W] = w_yl;
`ifdef ACT_STAT_EN
      if (r_neg1[k]) w_neg_pop = w_neg_pop + 16'd1;
      if ((r_mode1 == 2'd2) && !r_neg1[k] && ((w_x2 > w_clip2) || r_clip1[DATA_W-1]))
        w_clip_pop = w_clip_pop + 16'd1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_x1    <= '0;
      r_lk1   <= '0;
      r_neg1  <= '0;
      r_mode1 <= '0;
      r_clip1 <= '0;
    end else if (w_en1) begin
      r_v1 <= s_valid;
      if (s_valid) begin
        r_x1    <= s_data;
        r_lk1   <= w_lk;
        r_neg1  <= w_neg;
        r_mode1 <= s_mode;
        r_clip1 <= s_clip;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2 <= 1'b0;
      r_y2 <= '0;
    end else if (w_en2) begin
      r_v2 <= r_v1;
      if (r_v1) r_y2 <= w_y;
    end
  end

`ifdef ACT_STAT_EN
  assign w_neg_sum  = {1'b0, r_neg_cnt} + {1'b0, w_neg_pop};
  assign w_clip_sum = {1'b0, r_clip_cnt} + {1'b0, w_clip_pop};
  assign neg_cnt    = r_neg_cnt;
  assign clip_cnt   = r_clip_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_cnt  <= '0;
      r_clip_cnt <= '0;
    end else if (stat_clr) begin
      r_neg_cnt  <= '0;
      r_clip_cnt <= '0;
    end else if (w_en2 && r_v1) begin
      r_neg_cnt  <= w_neg_sum[16] ? 16'hFFFF : w_neg_sum[15:0];
      r_clip_cnt <= w_clip_sum[16] ? 16'hFFFF : w_clip_sum[15:0];
    end
  end
`endif

endmodule
